// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulus counter family.
// Mode and direction encodings used by module parameters and benches alike.
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  localparam bit CNT_DOWN = 1'b0;
  localparam bit CNT_UP   = 1'b1;

endpackage

// File: rtl/counter_next.sv
// Next-count unit: load / count / wrap-or-saturate decision for one stage.
// Latency: purely combinational.
// Backpressure: none; Enable is the only pacing input.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] next_count,
  output logic             at_tv,
  output logic             load_oor
);

  // One extra bit so MODULUS == 2**WIDTH is representable as a bound.
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] cnt_w;
  logic [WIDTH:0] din_w;
  logic [WIDTH:0] tv_w;
  logic [WIDTH:0] nxt_w;

  assign cnt_w = {1'b0, count};
  assign din_w = {1'b0, din};
  assign tv_w  = up ? MAX_W : '0;

  assign at_tv    = (cnt_w == tv_w);
  assign load_oor = (din_w > MAX_W);

  always_comb begin
    nxt_w = cnt_w;
    if (load) begin
      nxt_w = load_oor ? MAX_W : din_w;
    end else if (enable) begin
      if (at_tv) begin
        if (SATURATE == CNT_WRAP) begin
          nxt_w = up ? '0 : MAX_W;
        end
      end else begin
        nxt_w = up ? (cnt_w + 1'b1) : (cnt_w - 1'b1);
      end
    end
  end

  // Result is always below MODULUS, so the top bit is never set.
  assign next_count = WIDTH'(nxt_w);

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter with load, enable, wrap/saturate and cascade carry.
// Latency: Count/Wrapped/Load_err update on the sampling edge; Carry_out is combinational.
// Backpressure: none; chain stages by feeding Carry_out into the next Enable.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = CNT_WRAP
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Load,
  input  logic             Enable,
  input  logic             Up,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Count,
  output logic             Carry_out,
  output logic             Wrapped,
  output logic             Load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] next_count;
  logic             at_tv;
  logic             load_oor;

  counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (Count),
    .up         (Up),
    .enable     (Enable),
    .load       (Load),
    .din        (Din),
    .next_count (next_count),
    .at_tv      (at_tv),
    .load_oor   (load_oor)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      Count    <= '0;
      Wrapped  <= 1'b0;
      Load_err <= 1'b0;
    end else begin
      Count    <= next_count;
      Wrapped  <= ~Load & Enable & at_tv;
      Load_err <= Load & load_oor;
    end
  end

  assign Carry_out = Enable & at_tv;

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable, wrap-or-saturate mode and a cascade carry.
- Next-generation replacement for the fixed 4-bit binary up counter in the counter library.
- Used standalone as a modulo-N counter, or chained (Carry_out into the next stage's Enable) for wide or BCD-style counters.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- MODULUS, 16, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH
- SATURATE, 0, 0 = wrap at the terminal value, 1 = hold at the terminal value

- Clock  in  1  rising-edge clock, the only clock
- Clear  in  1  synchronous, active-high reset
- Load  in  1  active-high synchronous parallel load
- Enable  in  1  active-high count enable
- Up  in  1  direction: 1 = count up, 0 = count down
- Din  in  WIDTH  parallel load value
- Count  out  WIDTH  current count, registered
- Carry_out  out  1  combinational terminal-count indication for cascading
- Wrapped  out  1  registered one-cycle pulse on wrap or saturation
- Load_err  out  1  registered one-cycle pulse on an out-of-range load

## Operation
- Terminal value TV:
  - MODULUS-1 when Up=1.
  - 0 when Up=0.
- Per-edge priority is Clear > Load > Enable > hold.
- **Clear=1:**
  - Count←0, Wrapped←0, Load_err←0.
  - Load and Enable are ignored.
- **Load=1:**
  - If Din < MODULUS: Count←Din, Load_err←0.
  - Otherwise: Count←MODULUS-1, Load_err←1.
  - Load does not require Enable.
  - Wrapped←0.
- **Enable=1, Count≠TV:**
  - Count←Count+1 when Up=1.
  - Count←Count-1 when Up=0.
  - Wrapped←0.
- **Enable=1, Count=TV:**
  - SATURATE=0:
    - Up=1: Count←0.
    - Up=0: Count←MODULUS-1.
  - SATURATE=1: Count holds.
  - Wrapped←1 in both modes.
- **Enable=0:** Count holds, Wrapped←0, Load_err←0.
- Carry_out = Enable & (Count==TV).
  - Pure combinational; no dependence on Load or Clear.
  - Combinational input to the next stage's Enable.
- Direction change: Up may change on any cycle. The new direction takes effect on the same edge, with no extra latency and no skipped value.
- Arithmetic is performed at WIDTH+1 bits internally, so MODULUS=2^WIDTH wraps correctly with no overflow artefacts.
- Count is never outside 0..MODULUS-1 after the first Clear.

## Timing
- Latency: every registered output reflects the inputs sampled at the rising edge and updates on that edge.
- Reset values (after any edge with Clear=1): Count=0, Wrapped=0, Load_err=0.
  - Carry_out then equals Enable & ~Up.
- Clear in the middle of a count sequence takes effect on the next edge. Counting resumes from 0 on the first edge with Clear=0 and Enable=1.
- Load with Enable on the same edge: the load wins and no count is applied.
- Wrapped and Load_err are single-cycle pulses.
  - Back-to-back qualifying edges produce consecutive high cycles.
  - Example: SATURATE=1 held at TV with Enable=1 keeps Wrapped high on every such edge.
- Cascading: a stage's Enable driven from the previous stage's Carry_out advances exactly once per wrap of the lower stage, on the same edge.

## Structure
- Package counter_pkg holds:
  - the mode constants CNT_WRAP=0 and CNT_SAT=1;
  - the direction constants CNT_DOWN=0 and CNT_UP=1.
- Module parameters and bench both use these constants.
- One sub-module, counter_next: a combinational next-state unit.
  - Inputs: Count, Up, Enable, Load, Din.
  - Outputs: next count, the at-terminal flag, the load-out-of-range flag.
- The top level holds only registers, Clear priority and the Carry_out assignment.
- Elaboration-time check: error if MODULUS < 2 or MODULUS > 2^WIDTH.

## Test plan
- **Reset:** WIDTH=4, MODULUS=10, count to 7, assert Clear with Load=1 and Enable=1 → next edge Count=0, Wrapped=0, Load_err=0.
- **Up wrap:** MODULUS=10, Up=1, Enable=1 from 0 for 10 edges → Count 1..9 then 0.
  - Carry_out=1 while Count=9.
  - Wrapped=1 for the single cycle after the 9→0 edge.
- **Down wrap / saturate:** Up=0 from 2 with SATURATE=0 → 1, 0, 9, 8; Wrapped pulses after the 0→9 edge. Same stimulus with SATURATE=1 → 1, 0, 0, 0; Wrapped high on each edge at 0.
- **Load:** MODULUS=10.
  - Load Din=5 with Enable=1 → Count=5, no increment, Load_err=0.
  - Load Din=12 → Count=9, Load_err=1 for one cycle.
- **Cascade:** two WIDTH=4, MODULUS=10 instances, low stage's Carry_out driving the high stage's Enable, 100 enabled edges from 0.
  - Pair reads 99 at edge 99 and 00 at edge 100.
  - High-stage Wrapped pulses once.
- **Full-range and direction flip:** WIDTH=4, MODULUS=16, Up=1 from 14 → 15, 0. Flip Up=0 at Count=0 → next value 15, with no skipped value.
